// File: rtl/nts_tx_buffer_if.sv
// Engine-write and MAC-transmit signals of nts_tx_buffer, named from the buffer's point of view.
// slave = the buffer itself, master = whoever drives the engine and MAC sides.
interface nts_tx_buffer_if;
    logic        o_wr_ready;
    logic        i_wr_en;
    logic [63:0] i_wr_data;
    logic        i_wr_last;
    logic [7:0]  i_wr_data_valid;
    logic        i_wr_discard;
    logic        o_mac_tx_start;
    logic        i_mac_tx_ack;
    logic [7:0]  o_mac_tx_data_valid;
    logic [63:0] o_mac_tx_data;
    logic        o_tx_busy;
    logic        o_tx_overflow;
    logic        i_clear_overflow;
    logic [1:0]  o_dbg_tx_state;

    // Write side: a word is taken on a clock edge where i_wr_en and o_wr_ready are both high;
    // MAC side: the frame is requested by o_mac_tx_start and accepted on the edge i_mac_tx_ack is high.
    modport slave (
        output o_wr_ready,
        input  i_wr_en,
        input  i_wr_data,
        input  i_wr_last,
        input  i_wr_data_valid,
        input  i_wr_discard,
        output o_mac_tx_start,
        input  i_mac_tx_ack,
        output o_mac_tx_data_valid,
        output o_mac_tx_data,
        output o_tx_busy,
        output o_tx_overflow,
        input  i_clear_overflow,
        output o_dbg_tx_state
    );

    modport master (
        input  o_wr_ready,
        output i_wr_en,
        output i_wr_data,
        output i_wr_last,
        output i_wr_data_valid,
        output i_wr_discard,
        input  o_mac_tx_start,
        output i_mac_tx_ack,
        input  o_mac_tx_data_valid,
        input  o_mac_tx_data,
        input  o_tx_busy,
        input  o_tx_overflow,
        output i_clear_overflow,
        input  o_dbg_tx_state
    );
endinterface

// File: rtl/nts_tx_buffer.sv
// Ping-pong frame store between the NTS engine and the MAC TX port, streaming one word per cycle.
// Define NTS_TX_PAD_EN to zero-pad frames shorter than 60 bytes to exactly 60 bytes.
module nts_tx_buffer #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic           i_clk,
    input  logic           i_areset_n,
    nts_tx_buffer_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    typedef enum logic [1:0] {BUF_EMPTY, BUF_WRITING, BUF_READY, BUF_TRANSMIT} buf_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_STREAM} tx_state_e;

    logic [63:0]           mem_q [2*DEPTH];
    logic [63:0]           rd_data_q;

    buf_state_e            buf_q [2];
    buf_state_e            buf_d [2];
    logic [ADDR_WIDTH:0]   cnt_q [2];
    logic [ADDR_WIDTH:0]   cnt_d [2];
    logic [7:0]            mask_q [2];
    logic [7:0]            mask_d [2];

    logic                  wr_sel_q, wr_sel_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  drop_q, drop_d;
    logic                  ovf_q, ovf_d;
    logic                  mem_we;
    logic                  wr_ready;

    tx_state_e             tx_q, tx_d;
    logic                  rd_sel_q, rd_sel_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   cur_cnt;
    logic [7:0]            cur_mask;
    logic                  tx_last;

    assign wr_ready = (buf_q[wr_sel_q] == BUF_EMPTY) || (buf_q[wr_sel_q] == BUF_WRITING);
    assign cur_cnt  = cnt_q[rd_sel_q];
    assign cur_mask = mask_q[rd_sel_q];

    // The read address runs one word ahead of the word on the MAC bus; START prefetches word 0.
    assign rd_ptr = (tx_q == TX_STREAM) ? idx_q + 1'b1 : '0;

`ifdef NTS_TX_PAD_EN
    logic pad_frame;

    function automatic logic [63:0] expand_mask(input logic [7:0] m);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = {8{m[b]}};
        return r;
    endfunction

    // Under 60 bytes: fewer than 8 words, or 8 words with fewer than 4 bytes in the last one.
    assign pad_frame = (int'(cur_cnt) < 8) || ((int'(cur_cnt) == 8) && !cur_mask[4]);
    assign tx_last   = pad_frame ? (int'(idx_q) == 7) : (idx_q == cur_cnt - 1'b1);
`else
    assign tx_last   = (idx_q == cur_cnt - 1'b1);
`endif

    always_ff @(posedge i_clk) begin
        if (mem_we) mem_q[{wr_sel_q, wr_addr_q}] <= bus.i_wr_data;
        rd_data_q <= mem_q[{rd_sel_q, rd_ptr[ADDR_WIDTH-1:0]}];
    end

    always_comb begin
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        wr_sel_d  = wr_sel_q;
        wr_addr_d = wr_addr_q;
        drop_d    = drop_q;
        ovf_d     = ovf_q;
        mem_we    = 1'b0;
        tx_d      = tx_q;
        rd_sel_d  = rd_sel_q;
        idx_d     = idx_q;

        // A new overflow below overrides a clear in the same cycle.
        if (bus.i_clear_overflow) ovf_d = 1'b0;

        if (bus.i_wr_discard) begin
            if (buf_q[wr_sel_q] == BUF_WRITING) begin
                buf_d[wr_sel_q] = BUF_EMPTY;
                wr_addr_d       = '0;
            end
            // An abort also ends the tail of a frame that was dropped for overflow.
            drop_d = 1'b0;
        end else if (bus.i_wr_en && wr_ready) begin
            if (drop_q) begin
                if (bus.i_wr_last) drop_d = 1'b0;
            end else begin
                mem_we          = 1'b1;
                buf_d[wr_sel_q] = BUF_WRITING;
                if (bus.i_wr_last) begin
                    cnt_d[wr_sel_q]  = {1'b0, wr_addr_q} + 1'b1;
                    mask_d[wr_sel_q] = bus.i_wr_data_valid;
                    buf_d[wr_sel_q]  = BUF_READY;
                    wr_sel_d         = ~wr_sel_q;
                    wr_addr_d        = '0;
                end else if (wr_addr_q == ADDR_MAX) begin
                    buf_d[wr_sel_q] = BUF_EMPTY;
                    wr_addr_d       = '0;
                    ovf_d           = 1'b1;
                    drop_d          = 1'b1;
                end else begin
                    wr_addr_d = wr_addr_q + 1'b1;
                end
            end
        end

        // The write side only touches EMPTY/WRITING buffers and the TX side only READY/TRANSMIT ones.
        case (tx_q)
            TX_IDLE: begin
                idx_d = '0;
                if (buf_q[rd_sel_q] == BUF_READY) begin
                    buf_d[rd_sel_q] = BUF_TRANSMIT;
                    tx_d            = TX_START;
                end
            end
            TX_START: begin
                idx_d = '0;
                if (bus.i_mac_tx_ack) tx_d = TX_STREAM;
            end
            TX_STREAM: begin
                idx_d = idx_q + 1'b1;
                if (tx_last) begin
                    buf_d[rd_sel_q] = BUF_EMPTY;
                    rd_sel_d        = ~rd_sel_q;
                    tx_d            = TX_IDLE;
                end
            end
            default: tx_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_q[i]  <= BUF_EMPTY;
                cnt_q[i]  <= '0;
                mask_q[i] <= '0;
            end
            wr_sel_q  <= 1'b0;
            wr_addr_q <= '0;
            drop_q    <= 1'b0;
            ovf_q     <= 1'b0;
            tx_q      <= TX_IDLE;
            rd_sel_q  <= 1'b0;
            idx_q     <= '0;
        end else begin
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            wr_sel_q  <= wr_sel_d;
            wr_addr_q <= wr_addr_d;
            drop_q    <= drop_d;
            ovf_q     <= ovf_d;
            tx_q      <= tx_d;
            rd_sel_q  <= rd_sel_d;
            idx_q     <= idx_d;
        end
    end

    always_comb begin
        bus.o_mac_tx_data       = '0;
        bus.o_mac_tx_data_valid = '0;
        if (tx_q == TX_STREAM) begin
            bus.o_mac_tx_data       = rd_data_q;
            bus.o_mac_tx_data_valid = tx_last ? cur_mask : 8'hff;
`ifdef NTS_TX_PAD_EN
            if (pad_frame) begin
                bus.o_mac_tx_data_valid = tx_last ? 8'hf0 : 8'hff;
                if (int'(idx_q) >= int'(cur_cnt)) begin
                    bus.o_mac_tx_data = '0;
                end else if (idx_q == cur_cnt - 1'b1) begin
                    bus.o_mac_tx_data = rd_data_q & expand_mask(cur_mask);
                end
            end
`endif
        end
    end

    assign bus.o_wr_ready     = wr_ready;
    assign bus.o_mac_tx_start = (tx_q == TX_START);
    assign bus.o_tx_busy      = (tx_q != TX_IDLE);
    assign bus.o_tx_overflow  = ovf_q;
    assign bus.o_dbg_tx_state = tx_q;
endmodule

// File: tb/tb_nts_tx_buffer.sv
// Bench for nts_tx_buffer: random frames against a frame-level model of what the MAC must see.
// Honours NTS_TX_PAD_EN in its model when that macro is defined.
module tb_nts_tx_buffer;
    localparam int AW         = 4;
    localparam int DEPTH      = 2 ** AW;
    localparam int WAIT_BOUND = 400;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    nts_tx_buffer_if bus ();

    nts_tx_buffer #(.ADDR_WIDTH(AW)) dut (
        .i_clk      (clk),
        .i_areset_n (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [72:0] exp_q[$];   // {last, valid, data} in MAC order
    bit         in_frame = 1'b0;
    bit         ack_hold = 1'b0;
    int         ack_wait = 0;

    task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected MAC words for one written frame.
    function automatic void push_frame(input logic [63:0] w[$], input logic [7:0] mask);
        int          k;
        logic [63:0] tmp;
        logic [7:0]  v;
        k = w.size();
`ifdef NTS_TX_PAD_EN
        begin
            int         nbytes;
            logic [7:0] bytes [64];
            nbytes = 8 * (k - 1) + $countones(mask);
            if (nbytes < 60) begin
                for (int j = 0; j < 64; j++) bytes[j] = 8'h00;
                for (int j = 0; j < nbytes; j++) begin
                    tmp      = w[j / 8];
                    bytes[j] = tmp[63 - 8 * (j % 8) -: 8];
                end
                for (int i = 0; i < 8; i++) begin
                    for (int b = 0; b < 8; b++)
                        tmp[63 - 8 * b -: 8] = (8 * i + b < 60) ? bytes[8 * i + b] : 8'h00;
                    v = (i == 7) ? 8'hf0 : 8'hff;
                    exp_q.push_back({(i == 7), v, tmp});
                end
                return;
            end
        end
`endif
        for (int i = 0; i < k; i++) begin
            v = (i == k - 1) ? mask : 8'hff;
            exp_q.push_back({(i == k - 1), v, w[i]});
        end
    endfunction

    // MAC responder and scoreboard, sampled on the falling edge.
    initial begin : mac_monitor
        logic [72:0] e;
        bus.i_mac_tx_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame         = 1'b0;
                bus.i_mac_tx_ack = 1'b0;
            end else begin
                if (bus.i_mac_tx_ack) begin
                    bus.i_mac_tx_ack = 1'b0;
                    in_frame         = 1'b1;
                    check_eq("start_drop", {71'd0, bus.o_mac_tx_start}, 72'd0);
                end
                check_eq("busy", {71'd0, bus.o_tx_busy}, {71'd0, (bus.o_mac_tx_start | in_frame)});
                if (in_frame) begin
                    if (exp_q.size() == 0) begin
                        check_eq("tx_unexpected", {bus.o_mac_tx_data_valid, bus.o_mac_tx_data}, 72'd0);
                        in_frame = 1'b0;
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("tx_word", {bus.o_mac_tx_data_valid, bus.o_mac_tx_data}, e[71:0]);
                        if (e[72]) in_frame = 1'b0;
                    end
                end else begin
                    check_eq("idle_out", {bus.o_mac_tx_data_valid, bus.o_mac_tx_data}, 72'd0);
                end
                if (bus.o_mac_tx_start && !bus.i_mac_tx_ack && !ack_hold) begin
                    if (ack_wait == 0) begin
                        bus.i_mac_tx_ack = 1'b1;
                        ack_wait         = $urandom_range(0, 3);
                    end else begin
                        ack_wait--;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic wait_ready();
        int t = 0;
        while (!bus.o_wr_ready && t < WAIT_BOUND) begin
            @(negedge clk);
            t++;
        end
        if (t >= WAIT_BOUND) check_eq("wr_ready_timeout", {71'd0, bus.o_wr_ready}, 72'd1);
    endtask

    task automatic drive_word(input logic [63:0] d, input bit last, input logic [7:0] mask);
        wait_ready();
        bus.i_wr_en         = 1'b1;
        bus.i_wr_data       = d;
        bus.i_wr_last       = last;
        bus.i_wr_data_valid = last ? mask : 8'h00;
        @(negedge clk);
        bus.i_wr_en         = 1'b0;
        bus.i_wr_last       = 1'b0;
        bus.i_wr_data_valid = 8'h00;
    endtask

    // discard_at >= 0 aborts the frame after that many words instead of finishing it.
    task automatic write_frame(input int n, input logic [7:0] mask, input int discard_at, input bit gaps);
        logic [63:0] words[$];
        logic [63:0] d;
        for (int i = 0; i < n; i++) begin
            if (i == discard_at) begin
                bus.i_wr_discard = 1'b1;
                @(negedge clk);
                bus.i_wr_discard = 1'b0;
                return;
            end
            d = {$urandom, $urandom};
            words.push_back(d);
            if (i == n - 1 && n <= DEPTH) push_frame(words, mask);
            drive_word(d, (i == n - 1), mask);
            if (gaps && i < n - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || in_frame) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check_eq("drain_timeout", {40'd0, exp_q.size()}, 72'd0);
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ready"}, {71'd0, bus.o_wr_ready}, 72'd1);
        check_eq({tag, "_start"}, {71'd0, bus.o_mac_tx_start}, 72'd0);
        check_eq({tag, "_busy"},  {71'd0, bus.o_tx_busy}, 72'd0);
        check_eq({tag, "_txout"}, {bus.o_mac_tx_data_valid, bus.o_mac_tx_data}, 72'd0);
    endtask

    initial begin : main
        int          n;
        int          k;
        int          disc;
        logic [7:0]  m;
        bus.i_wr_en          = 1'b0;
        bus.i_wr_data        = '0;
        bus.i_wr_last        = 1'b0;
        bus.i_wr_data_valid  = '0;
        bus.i_wr_discard     = 1'b0;
        bus.i_clear_overflow = 1'b0;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check_eq("reset_ovf", {71'd0, bus.o_tx_overflow}, 72'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Three-word frame, ack on the second START cycle.
        ack_wait = 1;
        write_frame(3, 8'hfc, -1, 1'b0);
        wait_drain();
        check_idle_outputs("t1");

        // Two frames queued behind a stalled MAC.
        ack_hold = 1'b1;
        write_frame(10, 8'hff, -1, 1'b0);
        write_frame(4, 8'hc0, -1, 1'b0);
        check_eq("ready_both_full", {71'd0, bus.o_wr_ready}, 72'd0);
        repeat (20) @(negedge clk);
        ack_hold = 1'b0;
        wait_drain();
        check_idle_outputs("t2");

        // One word too many: dropped, sticky overflow, then cleared.
        write_frame(DEPTH + 1, 8'hff, -1, 1'b0);
        check_eq("ovf_set", {71'd0, bus.o_tx_overflow}, 72'd1);
        repeat (6) @(negedge clk);
        check_idle_outputs("t3");
        bus.i_clear_overflow = 1'b1;
        @(negedge clk);
        bus.i_clear_overflow = 1'b0;
        check_eq("ovf_clear", {71'd0, bus.o_tx_overflow}, 72'd0);

        // Exactly full buffer is legal.
        write_frame(DEPTH, 8'h80, -1, 1'b0);
        wait_drain();
        check_eq("full_no_ovf", {71'd0, bus.o_tx_overflow}, 72'd0);

        // Clear in the same cycle as a fresh overflow: overflow wins.
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) bus.i_clear_overflow = 1'b1;
            drive_word({$urandom, $urandom}, 1'b0, 8'h00);
            bus.i_clear_overflow = 1'b0;
        end
        drive_word({$urandom, $urandom}, 1'b1, 8'hff);
        check_eq("ovf_wins", {71'd0, bus.o_tx_overflow}, 72'd1);
        bus.i_clear_overflow = 1'b1;
        @(negedge clk);
        bus.i_clear_overflow = 1'b0;
        repeat (4) @(negedge clk);

        // Abort after five words, then a short frame.
        write_frame(6, 8'hff, 5, 1'b0);
        write_frame(2, 8'he0, -1, 1'b0);
        wait_drain();
        write_frame(1, 8'h80, -1, 1'b0);
        wait_drain();
        check_idle_outputs("t4");

        // Asynchronous reset in the middle of a stream.
        write_frame(12, 8'hf8, -1, 1'b0);
        begin
            int t = 0;
            while (!(in_frame && exp_q.size() <= 8) && t < WAIT_BOUND) begin
                @(negedge clk);
                t++;
            end
            if (t >= WAIT_BOUND) check_eq("stream_timeout", 72'd0, 72'd1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        exp_q.delete();
        in_frame = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        write_frame(3, 8'hfe, -1, 1'b0);
        wait_drain();
        check_idle_outputs("t5");

        // Random traffic with random gaps, ack delays and occasional aborts.
        for (int f = 0; f < 30; f++) begin
            n    = $urandom_range(1, DEPTH);
            k    = $urandom_range(1, 8);
            m    = 8'hff;
            m    = m << (8 - k);
            disc = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
            write_frame(n, m, disc, 1'b1);
        end
        wait_drain();
        check_idle_outputs("rand_end");
        check_eq("rand_ovf", {71'd0, bus.o_tx_overflow}, 72'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
